vertex_feeder: RTL

//  Initiator for the MVP transform engine. On frame_start: one matrix-update request, then every model vertex from ROM through a transform request.

---
 rtl/vertex_feeder_if.sv | 42 ++++
 rtl/vertex_feeder.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/vertex_feeder_if.sv
// rtl/vertex_feeder_if.sv - vertex ROM, MVP engine and rasterizer stream bundle for vertex_feeder
interface vertex_feeder_if #(
  parameter int ADDR_W = 10
);
  // vertex ROM
  logic [ADDR_W-1:0] rom_addr;
  logic [95:0]       rom_data;
  // MVP transform engine
  logic              mvp_start;
  logic              mvp_update;
  logic [31:0]       mvp_x;
  logic [31:0]       mvp_y;
  logic [31:0]       mvp_z;
  logic              mvp_done;
  logic [31:0]       mvp_ox;
  logic [31:0]       mvp_oy;
  logic [31:0]       mvp_oz;
  // rasterizer vertex stream
  logic              vtx_valid;
  logic              vtx_ready;
  logic [31:0]       vtx_x;
  logic [31:0]       vtx_y;
  logic [31:0]       vtx_z;
  logic              vtx_last;
  logic              vtx_clip;

  modport master (
    output rom_addr, input rom_data,
    output mvp_start, output mvp_update, output mvp_x, output mvp_y, output mvp_z,
    input mvp_done, input mvp_ox, input mvp_oy, input mvp_oz,
    output vtx_valid, input vtx_ready, output vtx_x, output vtx_y, output vtx_z,
    output vtx_last, output vtx_clip
  );

  modport slave (
    input rom_addr, output rom_data,
    input mvp_start, input mvp_update, input mvp_x, input mvp_y, input mvp_z,
    output mvp_done, output mvp_ox, output mvp_oy, output mvp_oz,
    input vtx_valid, output vtx_ready, input vtx_x, input vtx_y, input vtx_z,
    input vtx_last, input vtx_clip
  );
endinterface

// File: rtl/vertex_feeder.sv
// rtl/vertex_feeder.sv - frame sequencer feeding ROM vertices through the MVP engine into a rasterizer FIFO (clip flag under VERTEX_FEEDER_CLIP_EN)
module vertex_feeder #(
  parameter int ADDR_W     = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              frame_start_i,
  input  logic [ADDR_W-1:0] num_verts_i,
  vertex_feeder_if.master   bus,
  output logic              busy_o,
  output logic              frame_done_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);
  localparam int ENTRY_W = 98;

  typedef enum logic [3:0] {
    IDLE, UPD_REQ, UPD_ACK, UPD_WAIT, FETCH, LOAD, XF_REQ, XF_ACK, XF_WAIT, PUSH
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] nv_q, nv_d;
  logic              fetch_cnt_q, fetch_cnt_d;
  logic [31:0]       x_q, x_d, y_q, y_d, z_q, z_d;

  logic              start_w, update_w, push_w, frame_done_w, last_w, clip_w, pop_w;

  logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]     count_q;
  logic [ENTRY_W-1:0] head_w;

  assign last_w = (idx_q == nv_q - ADDR_W'(1));

`ifdef VERTEX_FEEDER_CLIP_EN
  assign clip_w = ($signed(bus.mvp_ox) < 0) | ($signed(bus.mvp_ox) > 639) |
                  ($signed(bus.mvp_oy) < 0) | ($signed(bus.mvp_oy) > 479) |
                  ($signed(bus.mvp_oz) < 0);
`else
  assign clip_w = 1'b0;
`endif

  // Frame sequencing: next state, ROM index, vertex latch and request strobes
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    nv_d         = nv_q;
    fetch_cnt_d  = 1'b0;
    x_d          = x_q;
    y_d          = y_q;
    z_d          = z_q;
    start_w      = 1'b0;
    update_w     = 1'b0;
    push_w       = 1'b0;
    frame_done_w = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (frame_start_i && bus.mvp_done) begin
          nv_d    = num_verts_i;
          idx_d   = '0;
          state_d = UPD_REQ;
        end
      end
      UPD_REQ: begin
        // Only fire into an idle engine; never re-request while it is working.
        if (bus.mvp_done) begin
          start_w  = 1'b1;
          update_w = 1'b1;
          state_d  = UPD_ACK;
        end
      end
      UPD_ACK: if (!bus.mvp_done) state_d = UPD_WAIT;
      UPD_WAIT: begin
        if (bus.mvp_done) begin
          if (nv_q == '0) begin
            frame_done_w = 1'b1;
            state_d      = IDLE;
          end else begin
            state_d = FETCH;
          end
        end
      end
      FETCH: begin
        // Two cycles of ROM read latency after rom_addr moves.
        if (fetch_cnt_q) state_d = LOAD;
        else fetch_cnt_d = 1'b1;
      end
      LOAD: begin
        x_d = bus.rom_data[95:64];
        y_d = bus.rom_data[63:32];
        z_d = bus.rom_data[31:0];
        // Only one vertex is ever in flight, so a free slot now guarantees room at PUSH.
        if (count_q != FULL_CNT) state_d = XF_REQ;
      end
      XF_REQ: begin
        if (bus.mvp_done) begin
          start_w = 1'b1;
          state_d = XF_ACK;
        end
      end
      XF_ACK:  if (!bus.mvp_done) state_d = XF_WAIT;
      XF_WAIT: if (bus.mvp_done) state_d = PUSH;
      PUSH: begin
        push_w = 1'b1;
        if (last_w) begin
          frame_done_w = 1'b1;
          idx_d        = '0;
          state_d      = IDLE;
        end else begin
          idx_d   = idx_q + ADDR_W'(1);
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer state registers
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      nv_q        <= '0;
      fetch_cnt_q <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      nv_q        <= nv_d;
      fetch_cnt_q <= fetch_cnt_d;
      x_q         <= x_d;
      y_q         <= y_d;
      z_q         <= z_d;
    end
  end

  assign pop_w = (count_q != '0) && bus.vtx_ready;

  // Output FIFO: storage and pointers; simultaneous push and pop keep the count steady
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_w) begin
        mem_q[wr_ptr_q] <= {bus.mvp_ox, bus.mvp_oy, bus.mvp_oz, last_w, clip_w};
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_w) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push_w && !pop_w)      count_q <= count_q + (PTR_W+1)'(1);
      else if (!push_w && pop_w) count_q <= count_q - (PTR_W+1)'(1);
    end
  end

  assign head_w = mem_q[rd_ptr_q];

  assign bus.rom_addr   = idx_q;
  assign bus.mvp_start  = start_w;
  assign bus.mvp_update = update_w;
  assign bus.mvp_x      = x_q;
  assign bus.mvp_y      = y_q;
  assign bus.mvp_z      = z_q;
  assign bus.vtx_valid  = (count_q != '0);
  assign bus.vtx_x      = head_w[97:66];
  assign bus.vtx_y      = head_w[65:34];
  assign bus.vtx_z      = head_w[33:2];
  assign bus.vtx_last   = head_w[1];
  assign bus.vtx_clip   = head_w[0];
  assign busy_o         = (state_q != IDLE);
  assign frame_done_o   = frame_done_w;

endmodule
